if_id_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/if_id_stage_if.sv | 27 ++
 rtl/imem_64x16.sv | 20 ++
 rtl/if_id_stage.sv | 61 ++++++
 tb/tb_if_id_stage.sv | 131 +++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, constants and FSM encodings for the fetch stage and IF/ID register.
package fetch_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] NOP_INSTR  = 16'h0000;
  localparam logic [7:0]        BUBBLE_MAX = 8'd255;

  typedef logic [1:0] state_t;
  localparam state_t S_BOOT  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_STALL = 2'd2;
endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side bus: PC/hazard controls and imem load port in, IF/ID register contents out.
interface if_id_stage_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc_in;
  logic              flush_in;
  logic              stall_in;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic [ADDR_W-1:0] ifid_pc_plus1;
  logic              ifid_valid;
  logic              ifid_stalled;
  logic [7:0]        bubble_count;

  modport master (
    output pc_in, flush_in, stall_in, imem_we, imem_waddr, imem_wdata,
    input  ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, ifid_stalled, bubble_count
  );

  modport slave (
    input  pc_in, flush_in, stall_in, imem_we, imem_waddr, imem_wdata,
    output ifid_instr, ifid_pc, ifid_pc_plus1, ifid_valid, ifid_stalled, bubble_count
  );
endinterface

// File: rtl/imem_64x16.sv
// 64-word instruction memory: combinational read, write on posedge, no reset, no bypass.
module imem_64x16
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address write/read in one cycle returns the old word.
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_stage.sv
// Fetch + IF/ID register: one-cycle fetch latency, one BOOT cycle after reset.
// Stall holds the register contents; flush inserts a NOP bubble and overrides stall.
module if_id_stage
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  if_id_stage_if.slave  bus
);
  state_t            state;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus1_q;
  logic              valid_q;
  logic [7:0]        bubble_q;
  logic [DATA_W-1:0] fetch_word;

  imem_64x16 u_imem (
    .clk   (clk),
    .we    (bus.imem_we),
    .waddr (bus.imem_waddr),
    .wdata (bus.imem_wdata),
    .raddr (bus.pc_in),
    .rdata (fetch_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BOOT;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      bubble_q   <= '0;
    end else if (state == S_BOOT) begin
      state <= S_RUN;
    end else if (bus.flush_in) begin
      state      <= S_RUN;
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
      if (bubble_q != BUBBLE_MAX) bubble_q <= bubble_q + 8'd1;
    end else if (bus.stall_in) begin
      state <= S_STALL;
    end else begin
      state      <= S_RUN;
      instr_q    <= fetch_word;
      pc_q       <= bus.pc_in;
      pc_plus1_q <= bus.pc_in + 1'b1;
      valid_q    <= 1'b1;
    end
  end

  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc       = pc_q;
  assign bus.ifid_pc_plus1 = pc_plus1_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.ifid_stalled  = (state == S_STALL);
  assign bus.bubble_count  = bubble_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed-vector bench for if_id_stage with hand-computed expectations.
module tb_if_id_stage;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  if_id_stage_if bus();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input logic [5:0] a, input logic [15:0] d);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = d;
    tick();
    bus.imem_we = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] instr, input logic [5:0] pc,
                           input logic [5:0] pcp1, input logic valid, input logic stalled,
                           input logic [7:0] cnt);
    check_vec({tag, ".instr"},   32'(bus.ifid_instr),    32'(instr));
    check_vec({tag, ".pc"},      32'(bus.ifid_pc),       32'(pc));
    check_vec({tag, ".pcp1"},    32'(bus.ifid_pc_plus1), 32'(pcp1));
    check_vec({tag, ".valid"},   32'(bus.ifid_valid),    32'(valid));
    check_vec({tag, ".stalled"}, 32'(bus.ifid_stalled),  32'(stalled));
    check_vec({tag, ".bubbles"}, 32'(bus.bubble_count),  32'(cnt));
  endtask

  initial begin
    logic [15:0] words [4];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    rst = 1'b1;
    bus.pc_in = '0; bus.flush_in = 1'b0; bus.stall_in = 1'b0;
    bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;

    // Memory loads are accepted while rst is held.
    for (int i = 0; i < 4; i++) write_mem(6'(i), words[i]);
    write_mem(6'd63, 16'hBEEF);
    write_mem(6'd5, 16'h5555);
    check_out("reset", 16'h0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0);

    // Reset edge already taken; next edge is BOOT, then captures.
    rst = 1'b0; bus.pc_in = 6'd9;
    tick();
    check_out("boot", 16'h0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      bus.pc_in = 6'(i);
      tick();
      check_out($sformatf("fetch%0d", i), words[i], 6'(i), 6'(i + 1), 1'b1, 1'b0, 8'd0);
    end

    bus.pc_in = 6'd63;
    tick();
    check_out("wrap63", 16'hBEEF, 6'd63, 6'd0, 1'b1, 1'b0, 8'd0);

    bus.stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pc_in = 6'(i + 1);
      tick();
      check_out($sformatf("stall%0d", i), 16'hBEEF, 6'd63, 6'd0, 1'b1, 1'b1, 8'd0);
    end
    bus.stall_in = 1'b0; bus.pc_in = 6'd1;
    tick();
    check_out("release", 16'h2222, 6'd1, 6'd2, 1'b1, 1'b0, 8'd0);

    bus.stall_in = 1'b1; bus.pc_in = 6'd2;
    tick();
    check_vec("prestall.stalled", 32'(bus.ifid_stalled), 32'd1);
    bus.flush_in = 1'b1;
    tick();
    check_out("flush_stall", 16'h0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd1);
    bus.flush_in = 1'b0; bus.stall_in = 1'b0;

    bus.pc_in = 6'd5;
    bus.imem_we = 1'b1; bus.imem_waddr = 6'd5; bus.imem_wdata = 16'hABCD;
    tick();
    bus.imem_we = 1'b0;
    check_vec("wr_same.old", 32'(bus.ifid_instr), 32'h5555);
    tick();
    check_vec("wr_same.new", 32'(bus.ifid_instr), 32'hABCD);

    bus.flush_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.flush_in = 1'b0;
    check_vec("flush6.bubbles", 32'(bus.bubble_count), 32'd7);
    bus.stall_in = 1'b1;
    tick();
    check_vec("prerst.stalled", 32'(bus.ifid_stalled), 32'd1);
    rst = 1'b1;
    tick();
    check_out("rst_stall", 16'h0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0; bus.stall_in = 1'b0; bus.pc_in = 6'd0;
    tick();
    check_out("reboot", 16'h0, 6'd0, 6'd0, 1'b0, 1'b0, 8'd0);
    tick();
    check_out("refetch", 16'h1111, 6'd0, 6'd1, 1'b1, 1'b0, 8'd0);

    bus.flush_in = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    check_vec("sat254", 32'(bus.bubble_count), 32'd254);
    for (int i = 0; i < 46; i++) tick();
    check_vec("sat255", 32'(bus.bubble_count), 32'd255);
    bus.flush_in = 1'b0; bus.pc_in = 6'd3;
    tick();
    check_out("post_sat", 16'h4444, 6'd3, 6'd4, 1'b1, 1'b0, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
